// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, framing constants and baud-divider helper for the UART TX path
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count, w_next;
  logic r_full, r_empty, w_push, w_pop;
  assign w_push = push && !r_full;
  assign w_pop = pop && !r_empty;
  assign w_next = (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                  (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= w_next;
      r_full <= w_next == (AW+1)'(DEPTH);
      r_empty <= w_next == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
  assign dout = r_mem[r_rd];
  assign full = r_full;
  assign empty = r_empty;
  assign count = r_count;
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: buffers characters in a FIFO and serialises them as 8N1 UART frames, LSB first
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [UART_DATA_BITS-1:0]  char_in,
  input  logic                       char_valid,
  output logic                       busy,
  output logic                       tx,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       idle
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW = $clog2(CPB);
  localparam logic [BW-1:0] LAST = BW'(CPB - 1);
  uart_state_t r_state;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic r_tx;
  logic [UART_DATA_BITS-1:0] w_head;
  logic w_pop, w_empty, w_full, w_tick;
  assign w_tick = r_baud == LAST;
  // The head is consumed both when leaving IDLE and when a stop bit rolls straight into the next start bit
  assign w_pop = !w_empty && (r_state == ST_IDLE || (r_state == ST_STOP && w_tick));
  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (char_valid),
    .pop   (w_pop),
    .din   (char_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_tx <= UART_IDLE_LEVEL;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_shift <= w_head;
          r_tx <= 1'b0;
          r_baud <= '0;
          r_state <= ST_START;
        end
        ST_START: if (w_tick) begin
          r_baud <= '0;
          r_bit <= '0;
          r_tx <= r_shift[0];
          r_state <= ST_DATA;
        end else r_baud <= r_baud + BW'(1);
        ST_DATA: if (w_tick) begin
          r_baud <= '0;
          if (r_bit == 3'(UART_DATA_BITS - 1)) begin
            r_tx <= UART_IDLE_LEVEL;
            r_state <= ST_STOP;
          end else begin
            r_shift <= r_shift >> 1;
            r_tx <= r_shift[1];
            r_bit <= r_bit + 3'd1;
          end
        end else r_baud <= r_baud + BW'(1);
        ST_STOP: if (w_tick) begin
          r_baud <= '0;
          if (!w_empty) begin
            r_shift <= w_head;
            r_tx <= 1'b0;
            r_state <= ST_START;
          end else r_state <= ST_IDLE;
        end else r_baud <= r_baud + BW'(1);
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign busy = w_full;
  assign tx = r_tx;
  assign idle = w_empty && r_state == ST_IDLE;
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Downstream consumer of the debug character stream. Accepts 8-bit characters through a valid/busy handshake into a small FIFO. Serialises each character onto a UART TX line in 8N1 format, LSB first. It provides the `uart_busy` back-pressure the debug printer expects, and drives the board's physical TX pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2).
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  8  character to transmit.
- char_valid  in  1  char_in is valid this cycle.
- busy  out  1  FIFO full; upstream must hold char_in and must not expect acceptance.
- tx  out  1  serial line, idle high.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- idle  out  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (async assert, sync release by design): FIFO empty; fifo_count=0; busy=0; tx=1; idle=1; FSM=IDLE; bit/baud counters=0. Reset mid-frame aborts the frame immediately and tx returns high.
- Handshake: a character is accepted on a posedge where char_valid=1 and busy=0. Every such cycle is one accepted character; no double-accept.
- busy is registered and equals (fifo_count==DEPTH). It is not combinationally dependent on char_valid.
- FIFO push and pop in the same cycle: count is unchanged, both take effect. Push while full is ignored (busy=1 guarantees this). Pop while empty never occurs.
- Pointers wrap modulo DEPTH. fifo_count is computed from extended pointers or a separate counter, range 0..DEPTH.
- FSM states:
  - IDLE -> START when fifo non-empty. At that edge the head is popped into an 8-bit shift register, tx<=0, and the baud counter is cleared.
  - START: holds tx=0 for CLKS_PER_BIT cycles, then -> DATA with tx<=shift[0] and bit_idx=0.
  - DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right and bit_idx increments. After bit 7 -> STOP with tx<=1.
  - STOP: holds tx=1 for CLKS_PER_BIT cycles. At the end it pops the next character and goes straight to START (no gap) if the FIFO is non-empty, else -> IDLE.
- Latency: a character accepted at edge E into an empty, idle block is popped at edge E+1. tx falls after E+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- tx is driven only from a flop; no glitches.
- Baud counter: 0..CLKS_PER_BIT-1, wraps at the bit boundary.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
  - Function clks_per_bit(CLK_FREQ, BAUD).
  - Constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout (registered head, first-word-fall-through), full, empty, count.
  - Same clock and reset as the parent.
  - uart_tx_buffer instantiates it and contains the serialiser FSM.

Test Plan:
All scenarios use CLK_FREQ=100_000_000, BAUD=10_000_000 (CLKS_PER_BIT=10), DEPTH=4.
1. Single character:
   - Stimulus: push 0x41 once into an idle block.
   - Required: tx low 1 cycle after acceptance. tx then follows 0,1,0,0,0,0,0,1,0,1, each level for exactly 10 cycles. idle returns to 1 after 100 cycles.
2. Back-pressure:
   - Stimulus: hold char_valid=1 with chars 0x30..0x35 on consecutive cycles, advancing only when busy=0.
   - Required: 0x30..0x34 accepted on 5 consecutive edges; busy=1 after the 5th. 0x35 is held until the 0x30 frame's stop bit ends (pop of 0x31), then accepted the next cycle. Line output order is 0x30..0x35.
3. Back-to-back frames:
   - Stimulus: push 0x55, 0xAA.
   - Required: the second start bit begins on the cycle immediately after the first stop bit's 10th cycle. Total busy-line time is 200 cycles.
4. Simultaneous push/pop at boundary:
   - Stimulus: with count=4, make the STOP->START pop coincide with char_valid.
   - Required: the push is refused that cycle (busy=1). The next cycle busy=0, the char is accepted, and count returns to 4.
5. Reset mid-frame:
   - Stimulus: assert rst_n=0 during DATA bit 3 with 2 chars queued.
   - Required: tx=1, count=0, busy=0, idle=1 asynchronously. After release no residual characters are transmitted.
6. Wrap-around:
   - Stimulus: stream 20 characters 0x00..0x13 through DEPTH=4.
   - Required: all 20 appear on tx in order with correct bits. fifo_count never exceeds 4.
